// File: rtl/sky130_gpio_pad_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sky130_gpio_pkg
// Shared types for the sky130 GPIOv2 pad-bank controller:
//   mode_e       - per-channel pad mode codes (6 and 7 are reserved and decode as OFF)
//   DM_*         - pad drive-mode constants
//   seq_state_e  - bank power/hold sequencer states
//   sel_e        - source selector for the pad OUT / OE_N registers
//   pad_cfg_t    - static decode of one mode: {dm, inp_dis, out_sel, oe_sel}
//   mode_decode  - mode code -> pad_cfg_t
//   sel_apply    - resolve a selector against the core gpio_out/gpio_oe bits
// ---------------------------------------------------------------------------
package sky130_gpio_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_IN    = 3'd1,
    MODE_IN_PD = 3'd2,
    MODE_IN_PU = 3'd3,
    MODE_OD    = 3'd4,
    MODE_PP    = 3'd5
  } mode_e;

  localparam logic [2:0] DM_ANALOG = 3'b000;
  localparam logic [2:0] DM_INPUT  = 3'b001;
  localparam logic [2:0] DM_PD     = 3'b010;
  localparam logic [2:0] DM_PU     = 3'b011;
  localparam logic [2:0] DM_STRONG = 3'b110;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_PWR,
    ST_EN,
    ST_EN_INP,
    ST_RUN,
    ST_HOLD,
    ST_REL
  } seq_state_e;

  typedef enum logic [1:0] {
    SEL_ZERO,  // constant 0
    SEL_ONE,   // constant 1
    SEL_OUT,   // gpio_out
    SEL_NOE    // ~gpio_oe
  } sel_e;

  typedef struct packed {
    logic [2:0] dm;
    logic       inp_dis;
    sel_e       out_sel;
    sel_e       oe_sel;
  } pad_cfg_t;

  function automatic pad_cfg_t mode_decode(input logic [2:0] mode);
    pad_cfg_t c;
    c.dm      = DM_ANALOG;
    c.inp_dis = 1'b1;
    c.out_sel = SEL_ZERO;
    c.oe_sel  = SEL_ONE;
    case (mode)
      MODE_IN: begin
        c.dm      = DM_INPUT;
        c.inp_dis = 1'b0;
      end
      MODE_IN_PD: begin
        c.dm      = DM_PD;
        c.inp_dis = 1'b0;
        c.oe_sel  = SEL_ZERO;
      end
      MODE_IN_PU: begin
        c.dm      = DM_PU;
        c.inp_dis = 1'b0;
        c.out_sel = SEL_ONE;
        c.oe_sel  = SEL_ZERO;
      end
      // Open drain: OUT held low, the driver is enabled only when gpio_out=0.
      MODE_OD: begin
        c.dm      = DM_STRONG;
        c.inp_dis = 1'b0;
        c.oe_sel  = SEL_OUT;
      end
      MODE_PP: begin
        c.dm      = DM_STRONG;
        c.inp_dis = 1'b0;
        c.out_sel = SEL_OUT;
        c.oe_sel  = SEL_NOE;
      end
      default: ;  // OFF and reserved codes keep the OFF encoding
    endcase
    return c;
  endfunction

  function automatic logic sel_apply(input sel_e sel, input logic out_b, input logic oe_b);
    logic v;
    v = 1'b0;
    case (sel)
      SEL_ONE: v = 1'b1;
      SEL_OUT: v = out_b;
      SEL_NOE: v = ~oe_b;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sky130_gpio_pad_ctrl_if.sv
// ---------------------------------------------------------------------------
// sky130_gpio_pad_ctrl_if
// Mode-change request channel (valid/ready) of the pad-bank controller.
//   cfg_valid  - request from the core (hold cfg_chan/cfg_mode stable until accepted)
//   cfg_ready  - controller can accept a request
//   cfg_chan   - target channel, $clog2(NCH) bits (min 1)
//   cfg_mode   - new 3-bit mode code
// master: core side, slave: controller side.
// ---------------------------------------------------------------------------
interface sky130_gpio_pad_ctrl_if #(
  parameter int NCH = 8
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [2:0]    cfg_mode;

  modport master (output cfg_valid, cfg_chan, cfg_mode, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_mode, output cfg_ready);
endinterface

// File: rtl/sky130_gpio_pad_ctrl_sync.sv
// ---------------------------------------------------------------------------
// sky130_gpio_sync
// SYNC_STAGES-deep, NCH-wide flop synchroniser for the pad IN pins.
//   clk, rst_n - core clock, async active-low reset (clears all stages to 0)
//   d_i        - asynchronous pad inputs
//   q_o        - synchronised value, SYNC_STAGES cycles behind d_i
// ---------------------------------------------------------------------------
module sky130_gpio_sync #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] d_i,
  output logic [NCH-1:0] q_o
);

  logic [NCH-1:0] stage_q [SYNC_STAGES];

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/sky130_gpio_pad_ctrl.sv
// ---------------------------------------------------------------------------
// sky130_gpio_pad_ctrl
// Core-side controller for one bank of NCH sky130 GPIOv2 pads: power
// sequences the bank, applies per-channel modes under pad hold, registers
// the output path and synchronises the input path.
//   clk, nreset        - core clock, async active-low reset
//   cfg                - mode-change request channel (slave modport)
//   ready              - power sequence complete
//   gpio_out/gpio_oe   - core output data / enable (PP mode uses gpio_oe)
//   gpio_in            - synchronised, gated pad input
//   pad_in             - pad IN pins
//   pad_out/pad_oe_n   - registered pad OUT / OE_N
//   pad_inp_dis/pad_dm - pad INP_DIS and DM (channel i at pad_dm[3i+2:3i])
//   pad_hld_h_n        - per-pad HLD_H_N
//   pad_enable_h       - bank ENABLE_H
//   pad_enable_inp_h   - bank ENABLE_INP_H
// ---------------------------------------------------------------------------
module sky130_gpio_pad_ctrl
  import sky130_gpio_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int PWR_DLY     = 16,
  parameter int HOLD_CYC    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   nreset,
  sky130_gpio_pad_ctrl_if.slave  cfg,
  output logic                   ready,
  input  logic [NCH-1:0]         gpio_out,
  input  logic [NCH-1:0]         gpio_oe,
  output logic [NCH-1:0]         gpio_in,
  input  logic [NCH-1:0]         pad_in,
  output logic [NCH-1:0]         pad_out,
  output logic [NCH-1:0]         pad_oe_n,
  output logic [NCH-1:0]         pad_inp_dis,
  output logic [3*NCH-1:0]       pad_dm,
  output logic [NCH-1:0]         pad_hld_h_n,
  output logic                   pad_enable_h,
  output logic                   pad_enable_inp_h
);

  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_MAX = (PWR_DLY > HOLD_CYC) ? PWR_DLY : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    tgt_chan_q, tgt_chan_d;
  logic [2:0]       tgt_mode_q, tgt_mode_d;
  logic             mode_wr;
  logic             chan_ok;
  logic [2:0]       mode_q [NCH];
  logic [NCH-1:0]   out_nxt, oe_n_nxt;
  logic [NCH-1:0]   pad_out_q, pad_oe_n_q;
  logic [NCH-1:0]   sync_q;

  assign chan_ok = (32'(cfg.cfg_chan) < NCH);

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      tgt_chan_q <= '0;
      tgt_mode_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_chan_q <= tgt_chan_d;
      tgt_mode_q <= tgt_mode_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_chan_d = tgt_chan_q;
    tgt_mode_d = tgt_mode_q;
    mode_wr    = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_PWR;
        cnt_d   = '0;
      end
      ST_PWR: begin
        if (cnt_q == PWR_LAST) begin
          state_d = ST_EN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EN:     state_d = ST_EN_INP;
      ST_EN_INP: state_d = ST_RUN;
      // Out-of-range channels complete the handshake but are dropped here.
      ST_RUN: begin
        if (cfg.cfg_valid && chan_ok) begin
          state_d    = ST_HOLD;
          cnt_d      = '0;
          tgt_chan_d = cfg.cfg_chan;
          tgt_mode_d = cfg.cfg_mode;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          mode_wr = 1'b1;
          state_d = ST_REL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REL:  state_d = ST_RUN;
      default: state_d = ST_RESET;
    endcase
  end

  assign pad_enable_h     = (state_q != ST_RESET) && (state_q != ST_PWR);
  assign pad_enable_inp_h = pad_enable_h && (state_q != ST_EN);
  assign ready            = (state_q == ST_RUN) || (state_q == ST_HOLD) || (state_q == ST_REL);
  assign cfg.cfg_ready    = (state_q == ST_RUN);

  // All pads held until the bank is up; during a mode change only the target.
  always_comb begin
    pad_hld_h_n = '0;
    if (state_q == ST_RUN) begin
      pad_hld_h_n = '1;
    end else if (state_q == ST_HOLD || state_q == ST_REL) begin
      pad_hld_h_n             = '1;
      pad_hld_h_n[tgt_chan_q] = 1'b0;
    end
  end

  // ---------------- per-channel mode registers ----------------
  // NOTE: the mode array is a handful of control flops, not a RAM, and the pads
  // must come up OFF, so every entry is explicitly reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NCH; i++) mode_q[i] <= MODE_OFF;
    end else if (mode_wr) begin
      mode_q[tgt_chan_q] <= tgt_mode_q;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pad_cfg_t pc;
    assign pc                = mode_decode(mode_q[i]);
    assign pad_dm[3*i +: 3]  = pc.dm;
    assign pad_inp_dis[i]    = pc.inp_dis;
    assign out_nxt[i]        = sel_apply(pc.out_sel, gpio_out[i], gpio_oe[i]);
    assign oe_n_nxt[i]       = sel_apply(pc.oe_sel, gpio_out[i], gpio_oe[i]);
  end

  // Output registers track the core except on channels whose pad is held.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pad_out_q  <= '0;
      pad_oe_n_q <= '1;
    end else begin
      pad_out_q  <= (out_nxt & pad_hld_h_n) | (pad_out_q & ~pad_hld_h_n);
      pad_oe_n_q <= (oe_n_nxt & pad_hld_h_n) | (pad_oe_n_q & ~pad_hld_h_n);
    end
  end

  assign pad_out  = pad_out_q;
  assign pad_oe_n = pad_oe_n_q;

  // ---------------- input path ----------------
  sky130_gpio_sync #(
    .NCH         (NCH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (nreset),
    .d_i   (pad_in),
    .q_o   (sync_q)
  );

  assign gpio_in = sync_q & ~pad_inp_dis & {NCH{pad_enable_inp_h}};

endmodule

// File: doc/sky130_gpio_pad_ctrl.md
# sky130_gpio_pad_ctrl

Parametrised core-side controller for a bank of `NCH` sky130 GPIOv2 pads. It power-sequences the bank (enable, input-enable, hold release) and maps a per-channel mode register onto the pad's DM/OE_N/INP_DIS/OUT controls. Mode changes are hold-protected, and pad inputs are synchronised into the core clock domain. It sits between core logic and the pad-ring instances, one controller per pad bank.

## Interface
- `NCH`, default 8: number of pad channels (1..32).
- `PWR_DLY`, default 16: cycles from reset release to `pad_enable_h` rise (>=1).
- `HOLD_CYC`, default 2: cycles a channel sits in hold before its mode register updates (>=1).
- `SYNC_STAGES`, default 2: input synchroniser depth (>=2).
- `clk` in 1: single clock.
- `nreset` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: mode-change request.
- `cfg_ready` out 1: controller can accept a request.
- `cfg_chan` in `$clog2(NCH)` (min 1): target channel.
- `cfg_mode` in 3: new mode.
- `ready` out 1: power sequence complete.
- `gpio_out` in NCH: core output data.
- `gpio_oe` in NCH: core output enable, used in PP mode.
- `gpio_in` out NCH: synchronised pad input.
- `pad_in` in NCH: pad IN pins.
- `pad_out` out NCH: pad OUT.
- `pad_oe_n` out NCH: pad OE_N.
- `pad_inp_dis` out NCH: pad INP_DIS.
- `pad_dm` out 3*NCH: pad DM; channel i occupies bits [3i+2:3i].
- `pad_hld_h_n` out NCH: per-pad HLD_H_N.
- `pad_enable_h` out 1: bank ENABLE_H.
- `pad_enable_inp_h` out 1: bank ENABLE_INP_H.

## Operation
- Mode encodings, giving DM / INP_DIS / OUT / OE_N:
  - OFF=0: 000 / 1 / 0 / 1.
  - IN=1: 001 / 0 / 0 / 1.
  - IN_PD=2: 010 / 0 / 0 / 0.
  - IN_PU=3: 011 / 0 / 1 / 0.
  - OD=4: 110 / 0 / 0 / `gpio_out`. Drives low only when `gpio_out`=0.
  - PP=5: 110 / 0 / `gpio_out` / `~gpio_oe`.
  - Codes 6 and 7 are reserved and decode as OFF.
- Per-channel mode registers reset to OFF.
- Sequencer states:
  - RESET: entered while `nreset`=0.
  - PWR: counts `PWR_DLY` cycles.
  - EN: `pad_enable_h`=1.
  - EN_INP: `pad_enable_inp_h`=1.
  - RUN: all `pad_hld_h_n`=1, `ready`=1, `cfg_ready`=1.
  - HOLD: target channel's `pad_hld_h_n`=0; counts `HOLD_CYC` cycles; mode register written on the last cycle.
  - REL: one cycle, hold still low, new mode values driven; then back to RUN.
- Transitions:
  - RESET→PWR on the first edge after release.
  - PWR→EN when the counter reaches `PWR_DLY`-1.
  - EN→EN_INP after 1 cycle.
  - EN_INP→RUN after 1 cycle.
  - RUN→HOLD on `cfg_valid && cfg_ready`.
- A request with `cfg_chan`>=NCH is accepted and dropped: the FSM stays in RUN and nothing changes.
- `cfg_ready` is 0 in every state other than RUN. Requests wait, and `cfg_*` must stay stable until accepted.
- While a channel's `pad_hld_h_n`=0, its `pad_out`/`pad_oe_n` registers are frozen. Other channels keep tracking `gpio_out`/`gpio_oe`.
- `gpio_in[i]`:
  - `pad_in[i]` passed through `SYNC_STAGES` flops.
  - ANDed with `~pad_inp_dis[i]`, so OFF channels read 0.
  - Forced 0 until `pad_enable_inp_h`=1.

## Timing
- Reset values: `pad_enable_h`=0, `pad_enable_inp_h`=0, `pad_hld_h_n`=0, `pad_dm`=0, `pad_inp_dis`=all 1, `pad_oe_n`=all 1, `pad_out`=0, `gpio_in`=0, `ready`=0, `cfg_ready`=0.
- Asserting `nreset` at any point forces all reset values immediately and asynchronously, including mid-HOLD. A pending mode change is lost.
- With edge 1 as the first edge after release:
  - `pad_enable_h` rises after edge `PWR_DLY`+1.
  - `pad_enable_inp_h` rises one cycle later.
  - `pad_hld_h_n`, `ready` and `cfg_ready` rise one cycle after that.
- Registered datapath: `gpio_out`/`gpio_oe` reach `pad_out`/`pad_oe_n` with 1 cycle latency.
- Input path: `pad_in` reaches `gpio_in` with `SYNC_STAGES` cycles latency.
- Mode change: acceptance at edge k.
  - `pad_hld_h_n[c]` falls after edge k.
  - New DM/INP_DIS appear after edge k+`HOLD_CYC`.
  - `pad_hld_h_n[c]` rises and `cfg_ready` returns after edge k+`HOLD_CYC`+1.
- Back-to-back requests: at most one per `HOLD_CYC`+2 cycles.

## Structure
- Package `sky130_gpio_pkg` holds:
  - the mode enum;
  - DM constants (`DM_ANALOG`, `DM_INPUT`, `DM_PD`, `DM_PU`, `DM_STRONG`);
  - the sequencer state enum;
  - a `mode_decode` function returning {dm, inp_dis, out_sel, oe_sel}.
- Sub-module `sky130_gpio_sync`: a `SYNC_STAGES`-deep, NCH-wide synchroniser with async active-low reset to 0.

## Test plan
- Reset release with `PWR_DLY`=16 → `pad_enable_h` rises after edge 17, `pad_enable_inp_h` after edge 18, `ready`/`cfg_ready`/all `pad_hld_h_n` after edge 19. All other outputs stay at reset values throughout.
- Write ch3 = PP, then `gpio_oe[3]`=1, `gpio_out[3]`=1 → `pad_dm[11:9]`=110; one cycle later `pad_out[3]`=1, `pad_oe_n[3]`=0; `pad_hld_h_n[3]` low for exactly `HOLD_CYC`+1=3 cycles.
- ch0 = OD, toggle `gpio_out[0]` → `pad_out[0]`=0 constantly, `pad_oe_n[0]` follows `gpio_out[0]` one cycle later. ch0 = mode 7 → OFF encoding.
- ch1 = IN, `pad_in[1]` pulse 0→1 → `gpio_in[1]` rises 2 cycles later. After ch1 = OFF → `gpio_in[1]`=0 regardless of `pad_in`.
- `cfg_chan`=9 with NCH=8 → accepted in one cycle, no `pad_hld_h_n` drop, no register change.
- `nreset` asserted during HOLD of ch2 → all outputs return to reset values in the same cycle; after the re-sequence, ch2 mode = OFF.
